// File: rtl/memwb_pipe_stage.sv
// MEM/WB pipeline register built as a two-entry skid buffer with registered in_ready.
// Optional stall/flush performance counters are enabled by defining MEMWB_PIPE_PERF_EN.
module memwb_pipe_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_read_data,
    input  logic [DATA_W-1:0] in_alu_out,
    input  logic [REG_W-1:0]  in_write_reg,
    input  logic              in_memtoreg,
    input  logic              in_wr_en,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_read_data,
    output logic [DATA_W-1:0] out_alu_out,
    output logic [DATA_W-1:0] out_wb_data,
    output logic [REG_W-1:0]  out_write_reg,
    output logic              out_memtoreg,
    output logic              out_wr_en
`ifdef MEMWB_PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    typedef struct packed {
        logic [DATA_W-1:0] read_data;
        logic [DATA_W-1:0] alu_out;
        logic [REG_W-1:0]  write_reg;
        logic              memtoreg;
        logic              wr_en;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state, state_next;
    entry_t main_entry, skid_entry, in_entry;
    logic   in_xfer, out_xfer;
    logic   main_from_in, main_from_skid, skid_from_in;

    assign in_entry = '{read_data: in_read_data, alu_out: in_alu_out,
                        write_reg: in_write_reg, memtoreg: in_memtoreg,
                        wr_en: in_wr_en};

    assign out_valid = (state != EMPTY);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_comb begin
        state_next     = state;
        main_from_in   = 1'b0;
        main_from_skid = 1'b0;
        skid_from_in   = 1'b0;
        unique case (state)
            EMPTY: begin
                if (in_xfer) begin
                    state_next   = ONE;
                    main_from_in = 1'b1;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    main_from_in = 1'b1;
                end else if (in_xfer) begin
                    state_next   = TWO;
                    skid_from_in = 1'b1;
                end else if (out_xfer) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                if (out_xfer) begin
                    state_next     = ONE;
                    main_from_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
        // Flush wins over any transfer; the held data is simply orphaned.
        if (flush) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_next;
            in_ready <= (state_next != TWO);
        end
    end

    // Payload registers carry no reset; validity lives entirely in state.
    always_ff @(posedge clk) begin
        if (main_from_in) begin
            main_entry <= in_entry;
        end else if (main_from_skid) begin
            main_entry <= skid_entry;
        end
        if (skid_from_in) begin
            skid_entry <= in_entry;
        end
    end

    assign out_read_data = main_entry.read_data;
    assign out_alu_out   = main_entry.alu_out;
    assign out_write_reg = main_entry.write_reg;
    assign out_memtoreg  = main_entry.memtoreg;
    assign out_wb_data   = main_entry.memtoreg ? main_entry.read_data : main_entry.alu_out;
    assign out_wr_en     = out_valid & main_entry.wr_en;

`ifdef MEMWB_PIPE_PERF_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (flush) begin
                flush_cnt <= sat_inc(flush_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_memwb_pipe_stage.sv
// Directed-vector bench for memwb_pipe_stage; exercises the perf counters when
// MEMWB_PIPE_PERF_EN is defined.
module tb_memwb_pipe_stage;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_read_data;
    logic [DATA_W-1:0] in_alu_out;
    logic [REG_W-1:0]  in_write_reg;
    logic              in_memtoreg;
    logic              in_wr_en;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_read_data;
    logic [DATA_W-1:0] out_alu_out;
    logic [DATA_W-1:0] out_wb_data;
    logic [REG_W-1:0]  out_write_reg;
    logic              out_memtoreg;
    logic              out_wr_en;
`ifdef MEMWB_PIPE_PERF_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    memwb_pipe_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_read_data (in_read_data),
        .in_alu_out   (in_alu_out),
        .in_write_reg (in_write_reg),
        .in_memtoreg  (in_memtoreg),
        .in_wr_en     (in_wr_en),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_read_data(out_read_data),
        .out_alu_out  (out_alu_out),
        .out_wb_data  (out_wb_data),
        .out_write_reg(out_write_reg),
        .out_memtoreg (out_memtoreg),
        .out_wr_en    (out_wr_en)
`ifdef MEMWB_PIPE_PERF_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] rd, input logic [DATA_W-1:0] alu,
                         input logic [REG_W-1:0] wr, input logic m2r, input logic we);
        in_valid     = v;
        in_read_data = rd;
        in_alu_out   = alu;
        in_write_reg = wr;
        in_memtoreg  = m2r;
        in_wr_en     = we;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_wr_en", out_wr_en, 0);
        check("rst_in_ready", in_ready, 1);
`ifdef MEMWB_PIPE_PERF_EN
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_flush_cnt", flush_cnt, 0);
`endif

        // Single entry through with one-cycle latency.
        rst       = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 32'h0, 32'h0000_00A5, 5'd7, 1'b0, 1'b1);
        tick();
        check("single_valid", out_valid, 1);
        check("single_wb_data", out_wb_data, 32'h0000_00A5);
        check("single_write_reg", out_write_reg, 7);
        check("single_wr_en", out_wr_en, 1);
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        tick();
        check("single_drain_valid", out_valid, 0);

        // Backpressure: fill both entries, third is refused, then drain in order.
        out_ready = 1'b0;
        drive(1'b1, 32'd1, 32'hDEAD, 5'd3, 1'b1, 1'b1);
        tick();
        check("bp1_in_ready", in_ready, 1);
        check("bp1_wb_data", out_wb_data, 1);
        check("bp1_read_data", out_read_data, 1);
        check("bp1_alu_out", out_alu_out, 32'hDEAD);
        check("bp1_memtoreg", out_memtoreg, 1);
        drive(1'b1, 32'd2, 32'hDEAD, 5'd4, 1'b1, 1'b1);
        tick();
        check("bp2_in_ready", in_ready, 0);
        check("bp2_wb_data", out_wb_data, 1);
        drive(1'b1, 32'd3, 32'hDEAD, 5'd5, 1'b1, 1'b1);
        tick();
        check("bp3_in_ready", in_ready, 0);
        check("bp3_stable_wb", out_wb_data, 1);
        check("bp3_stable_reg", out_write_reg, 3);
        out_ready = 1'b1;
        tick();
        check("drain2_valid", out_valid, 1);
        check("drain2_wb_data", out_wb_data, 2);
        check("drain2_in_ready", in_ready, 1);
        tick();
        check("drain3_wb_data", out_wb_data, 3);
        check("drain3_write_reg", out_write_reg, 5);
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
        tick();
        check("drain_empty_valid", out_valid, 0);
        check("drain_empty_wr_en", out_wr_en, 0);

        // Flush while full with a simultaneous input.
        out_ready = 1'b0;
        drive(1'b1, 32'h0, 32'h11, 5'd1, 1'b0, 1'b1);
        tick();
        drive(1'b1, 32'h0, 32'h22, 5'd2, 1'b0, 1'b1);
        tick();
        check("fl_full_in_ready", in_ready, 0);
        flush = 1'b1;
        drive(1'b1, 32'h0, 32'h33, 5'd3, 1'b0, 1'b1);
        tick();
        check("fl_out_valid", out_valid, 0);
        check("fl_out_wr_en", out_wr_en, 0);
        check("fl_in_ready", in_ready, 1);
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
        tick();
        check("fl_stays_empty", out_valid, 0);
        drive(1'b1, 32'h0, 32'h44, 5'd4, 1'b0, 1'b1);
        tick();
        check("fl_next_wb_data", out_wb_data, 32'h44);
        check("fl_next_write_reg", out_write_reg, 4);
`ifdef MEMWB_PIPE_PERF_EN
        check("fl_flush_cnt", flush_cnt, 1);
`endif

        // Streaming: one output per cycle with no gaps or repeats.
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 32'hFFFF_FFFF, 32'(i + 256), 5'(i), 1'b0, 1'b1);
            tick();
            check("stream_valid", out_valid, 1);
            check("stream_wb_data", out_wb_data, 64'(i + 256));
        end
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        tick();
        check("stream_end_valid", out_valid, 0);

        // Long stall while full, then reset mid-operation.
        out_ready = 1'b0;
        drive(1'b1, 32'h0, 32'h55, 5'd9, 1'b0, 1'b1);
        tick();
        drive(1'b1, 32'h0, 32'h66, 5'd10, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) tick();
        check("stall_in_ready", in_ready, 0);
        check("stall_wb_data", out_wb_data, 32'h55);
`ifdef MEMWB_PIPE_PERF_EN
        check("stall_cnt_sat", stall_cnt, 15);
`endif
        rst   = 1'b1;
        flush = 1'b1;
        tick();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_wr_en", out_wr_en, 0);
        check("mid_rst_in_ready", in_ready, 1);
`ifdef MEMWB_PIPE_PERF_EN
        check("mid_rst_stall_cnt", stall_cnt, 0);
        check("mid_rst_flush_cnt", flush_cnt, 0);
`endif
        rst   = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        tick();
        check("post_rst_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
